// File: rtl/control_unit_if.sv
// Control bus between the control unit and the datapath:
// IR/condition/memory status in, register and datapath strobes out.
interface control_unit_if;
    logic [31:0] ir;
    logic        con;
    logic        mem_rdy;

    logic        Gra;
    logic        Grb;
    logic        Grc;
    logic        Rin;
    logic        Rout;
    logic        BAout;

    logic        PCout;
    logic        PCin;
    logic        IncPC;
    logic        IRin;
    logic        MARin;
    logic        MDRin;
    logic        MDRout;
    logic        MDRread;
    logic        wren;

    logic        Yin;
    logic        Zlowin;
    logic        Zhighin;
    logic        ZLowout;
    logic        ZHighout;
    logic        HIout;
    logic        LOout;
    logic        Cout;
    logic        InPortout;
    logic        OPin;
    logic        conffin;

    logic [3:0]  ALUselect;
    logic        run;

    modport master (
        input  ir, con, mem_rdy,
        output Gra, Grb, Grc, Rin, Rout, BAout,
        output PCout, PCin, IncPC, IRin, MARin, MDRin, MDRout, MDRread, wren,
        output Yin, Zlowin, Zhighin, ZLowout, ZHighout, HIout, LOout,
        output Cout, InPortout, OPin, conffin,
        output ALUselect, run
    );

    modport slave (
        output ir, con, mem_rdy,
        input  Gra, Grb, Grc, Rin, Rout, BAout,
        input  PCout, PCin, IncPC, IRin, MARin, MDRin, MDRout, MDRread, wren,
        input  Yin, Zlowin, Zhighin, ZLowout, ZHighout, HIout, LOout,
        input  Cout, InPortout, OPin, conffin,
        input  ALUselect, run
    );
endinterface

// File: rtl/control_unit.sv
// Moore control sequencer: fetch T0-T2, opcode-specific execute T3-T7,
// with memory wait states in T1, ld-T6 and st-T7.
module control_unit (
    input  logic           clk,
    input  logic           clr,
    control_unit_if.master bus
);

    typedef enum logic [3:0] {
        S_RST, S_T0, S_T1, S_T2, S_T3,
        S_T4, S_T5, S_T6, S_T7, S_HALT
    } state_e;

    localparam logic [4:0] OP_LD   = 5'b00000;
    localparam logic [4:0] OP_LDI  = 5'b00001;
    localparam logic [4:0] OP_ST   = 5'b00010;
    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_ADDI = 5'b01100;
    localparam logic [4:0] OP_ANDI = 5'b01101;
    localparam logic [4:0] OP_ORI  = 5'b01110;
    localparam logic [4:0] OP_BR   = 5'b10011;
    localparam logic [4:0] OP_JAL  = 5'b10100;
    localparam logic [4:0] OP_JR   = 5'b10101;
    localparam logic [4:0] OP_IN   = 5'b10110;
    localparam logic [4:0] OP_OUT  = 5'b10111;
    localparam logic [4:0] OP_MFLO = 5'b11000;
    localparam logic [4:0] OP_MFHI = 5'b11001;
    localparam logic [4:0] OP_HALT = 5'b11011;

    state_e     state_q, state_d;
    logic [4:0] op;

    logic is_alu, is_imm, is_ldi, is_ld, is_st, is_br;
    logic is_jr, is_jal, is_in, is_out, is_mflo, is_mfhi, is_halt;
    logic [3:0] alu_sel;

    assign op = bus.ir[31:27];

    always_comb begin
        is_alu  = 1'b0;
        is_imm  = 1'b0;
        is_ldi  = 1'b0;
        is_ld   = 1'b0;
        is_st   = 1'b0;
        is_br   = 1'b0;
        is_jr   = 1'b0;
        is_jal  = 1'b0;
        is_in   = 1'b0;
        is_out  = 1'b0;
        is_mflo = 1'b0;
        is_mfhi = 1'b0;
        is_halt = 1'b0;
        alu_sel = 4'd0;
        case (op)
            OP_LD:   is_ld = 1'b1;
            OP_LDI:  is_ldi = 1'b1;
            OP_ST:   is_st = 1'b1;
            OP_ADD:  begin is_alu = 1'b1; alu_sel = 4'd0; end
            OP_SUB:  begin is_alu = 1'b1; alu_sel = 4'd1; end
            OP_AND:  begin is_alu = 1'b1; alu_sel = 4'd2; end
            OP_OR:   begin is_alu = 1'b1; alu_sel = 4'd3; end
            OP_ADDI: begin is_imm = 1'b1; alu_sel = 4'd0; end
            OP_ANDI: begin is_imm = 1'b1; alu_sel = 4'd2; end
            OP_ORI:  begin is_imm = 1'b1; alu_sel = 4'd3; end
            OP_BR:   is_br = 1'b1;
            OP_JAL:  is_jal = 1'b1;
            OP_JR:   is_jr = 1'b1;
            OP_IN:   is_in = 1'b1;
            OP_OUT:  is_out = 1'b1;
            OP_MFLO: is_mflo = 1'b1;
            OP_MFHI: is_mfhi = 1'b1;
            OP_HALT: is_halt = 1'b1;
            default: ;
        endcase
    end

    always_comb begin
        state_d = S_RST;
        case (state_q)
            S_RST:  state_d = S_T0;
            S_T0:   state_d = S_T1;
            S_T1:   state_d = bus.mem_rdy ? S_T2 : S_T1;
            S_T2:   state_d = S_T3;
            S_T3: begin
                if (is_halt)
                    state_d = S_HALT;
                else if (is_alu || is_imm || is_ldi || is_ld ||
                         is_st || is_br || is_jal)
                    state_d = S_T4;
                else
                    state_d = S_T0;
            end
            S_T4: begin
                if (is_alu || is_imm || is_ldi || is_ld || is_st || is_br)
                    state_d = S_T5;
                else
                    state_d = S_T0;
            end
            S_T5:   state_d = (is_ld || is_st || is_br) ? S_T6 : S_T0;
            S_T6: begin
                if (is_ld)
                    state_d = bus.mem_rdy ? S_T7 : S_T6;
                else if (is_st)
                    state_d = S_T7;
                else
                    state_d = S_T0;
            end
            S_T7:   state_d = (is_st && !bus.mem_rdy) ? S_T7 : S_T0;
            S_HALT: state_d = S_HALT;
            default: state_d = S_RST;
        endcase
    end

    always_ff @(posedge clk) begin
        if (clr)
            state_q <= S_RST;
        else
            state_q <= state_d;
    end

    // Pure Moore decode: state plus current opcode (and con for br-T6)
    always_comb begin
        bus.Gra       = 1'b0;
        bus.Grb       = 1'b0;
        bus.Grc       = 1'b0;
        bus.Rin       = 1'b0;
        bus.Rout      = 1'b0;
        bus.BAout     = 1'b0;
        bus.PCout     = 1'b0;
        bus.PCin      = 1'b0;
        bus.IncPC     = 1'b0;
        bus.IRin      = 1'b0;
        bus.MARin     = 1'b0;
        bus.MDRin     = 1'b0;
        bus.MDRout    = 1'b0;
        bus.MDRread   = 1'b0;
        bus.wren      = 1'b0;
        bus.Yin       = 1'b0;
        bus.Zlowin    = 1'b0;
        bus.Zhighin   = 1'b0;
        bus.ZLowout   = 1'b0;
        bus.ZHighout  = 1'b0;
        bus.HIout     = 1'b0;
        bus.LOout     = 1'b0;
        bus.Cout      = 1'b0;
        bus.InPortout = 1'b0;
        bus.OPin      = 1'b0;
        bus.conffin   = 1'b0;
        bus.ALUselect = 4'd0;
        bus.run       = (state_q != S_RST) && (state_q != S_HALT);
        case (state_q)
            S_T0: begin
                bus.PCout = 1'b1;
                bus.MARin = 1'b1;
                bus.IncPC = 1'b1;
            end
            S_T1: begin
                bus.MDRread = 1'b1;
                bus.MDRin   = 1'b1;
            end
            S_T2: begin
                bus.MDRout = 1'b1;
                bus.IRin   = 1'b1;
            end
            S_T3: begin
                if (is_alu || is_imm) begin
                    bus.Grb  = 1'b1;
                    bus.Rout = 1'b1;
                    bus.Yin  = 1'b1;
                end else if (is_ldi || is_ld || is_st) begin
                    bus.Grb   = 1'b1;
                    bus.BAout = 1'b1;
                    bus.Yin   = 1'b1;
                end else if (is_br) begin
                    bus.Gra     = 1'b1;
                    bus.Rout    = 1'b1;
                    bus.conffin = 1'b1;
                end else if (is_jr) begin
                    bus.Gra  = 1'b1;
                    bus.Rout = 1'b1;
                    bus.PCin = 1'b1;
                end else if (is_jal) begin
                    bus.PCout = 1'b1;
                    bus.Grb   = 1'b1;
                    bus.Rin   = 1'b1;
                end else if (is_in) begin
                    bus.InPortout = 1'b1;
                    bus.Gra       = 1'b1;
                    bus.Rin       = 1'b1;
                end else if (is_out) begin
                    bus.Gra  = 1'b1;
                    bus.Rout = 1'b1;
                    bus.OPin = 1'b1;
                end else if (is_mfhi) begin
                    bus.HIout = 1'b1;
                    bus.Gra   = 1'b1;
                    bus.Rin   = 1'b1;
                end else if (is_mflo) begin
                    bus.LOout = 1'b1;
                    bus.Gra   = 1'b1;
                    bus.Rin   = 1'b1;
                end
            end
            S_T4: begin
                if (is_alu) begin
                    bus.Grc       = 1'b1;
                    bus.Rout      = 1'b1;
                    bus.ALUselect = alu_sel;
                    bus.Zlowin    = 1'b1;
                end else if (is_imm || is_ldi || is_ld || is_st) begin
                    bus.Cout      = 1'b1;
                    bus.ALUselect = alu_sel;
                    bus.Zlowin    = 1'b1;
                end else if (is_br) begin
                    bus.PCout = 1'b1;
                    bus.Yin   = 1'b1;
                end else if (is_jal) begin
                    bus.Gra  = 1'b1;
                    bus.Rout = 1'b1;
                    bus.PCin = 1'b1;
                end
            end
            S_T5: begin
                if (is_alu || is_imm || is_ldi) begin
                    bus.ZLowout = 1'b1;
                    bus.Gra     = 1'b1;
                    bus.Rin     = 1'b1;
                end else if (is_ld || is_st) begin
                    bus.ZLowout = 1'b1;
                    bus.MARin   = 1'b1;
                end else if (is_br) begin
                    bus.Cout   = 1'b1;
                    bus.Zlowin = 1'b1;
                end
            end
            S_T6: begin
                if (is_ld) begin
                    bus.MDRread = 1'b1;
                    bus.MDRin   = 1'b1;
                end else if (is_st) begin
                    bus.Gra   = 1'b1;
                    bus.Rout  = 1'b1;
                    bus.MDRin = 1'b1;
                end else if (is_br) begin
                    bus.ZLowout = 1'b1;
                    bus.PCin    = bus.con;
                end
            end
            S_T7: begin
                if (is_ld) begin
                    bus.MDRout = 1'b1;
                    bus.Gra    = 1'b1;
                    bus.Rin    = 1'b1;
                end else if (is_st) begin
                    bus.wren = 1'b1;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit: opcode table through full instruction
// sequences, plus memory-wait, halt and reset-in-wait corner cases.
module tb_control_unit;

    logic clk = 1'b0;
    logic clr;

    control_unit_if ifc ();

    control_unit dut (
        .clk (clk),
        .clr (clr),
        .bus (ifc)
    );

    always #5 clk = ~clk;

    localparam logic [30:0] B1       = 31'd1;
    localparam logic [30:0] GRA      = B1 << 30;
    localparam logic [30:0] GRB      = B1 << 29;
    localparam logic [30:0] GRC      = B1 << 28;
    localparam logic [30:0] RIN      = B1 << 27;
    localparam logic [30:0] ROUT     = B1 << 26;
    localparam logic [30:0] BAOUT    = B1 << 25;
    localparam logic [30:0] PCOUT    = B1 << 24;
    localparam logic [30:0] PCIN     = B1 << 23;
    localparam logic [30:0] INCPC    = B1 << 22;
    localparam logic [30:0] IRIN     = B1 << 21;
    localparam logic [30:0] MARIN    = B1 << 20;
    localparam logic [30:0] MDRIN    = B1 << 19;
    localparam logic [30:0] MDROUT   = B1 << 18;
    localparam logic [30:0] MDRREAD  = B1 << 17;
    localparam logic [30:0] WREN     = B1 << 16;
    localparam logic [30:0] YIN      = B1 << 15;
    localparam logic [30:0] ZLOWIN   = B1 << 14;
    localparam logic [30:0] ZLOWOUT  = B1 << 12;
    localparam logic [30:0] HIOUT    = B1 << 10;
    localparam logic [30:0] LOOUT    = B1 << 9;
    localparam logic [30:0] COUT     = B1 << 8;
    localparam logic [30:0] INPORT   = B1 << 7;
    localparam logic [30:0] OPIN     = B1 << 6;
    localparam logic [30:0] CONFFIN  = B1 << 5;
    localparam logic [30:0] RUN      = B1;
    localparam logic [30:0] NONE     = 31'd0;

    localparam logic [30:0] F0 = PCOUT | MARIN | INCPC | RUN;
    localparam logic [30:0] F1 = MDRREAD | MDRIN | RUN;
    localparam logic [30:0] F2 = MDROUT | IRIN | RUN;

    localparam logic [30:0] E_RRY  = GRB | ROUT | YIN | RUN;
    localparam logic [30:0] E_BAY  = GRB | BAOUT | YIN | RUN;
    localparam logic [30:0] E_WB   = ZLOWOUT | GRA | RIN | RUN;
    localparam logic [30:0] E_CZ   = COUT | ZLOWIN | RUN;
    localparam logic [30:0] E_ZMAR = ZLOWOUT | MARIN | RUN;

    typedef struct packed {
        logic [4:0]        op;
        logic              con;
        logic [2:0]        n;
        logic [4:0][30:0]  exp;
    } vec_t;

    int n_cmp = 0;
    int n_bad = 0;

    function automatic logic [30:0] alu(input int v);
        return 31'(v) << 1;
    endfunction

    function automatic vec_t mk(input logic [4:0] op, input logic con,
                                input int n,
                                input logic [30:0] e3, input logic [30:0] e4,
                                input logic [30:0] e5, input logic [30:0] e6,
                                input logic [30:0] e7);
        vec_t v;
        v.op     = op;
        v.con    = con;
        v.n      = 3'(n);
        v.exp[0] = e3;
        v.exp[1] = e4;
        v.exp[2] = e5;
        v.exp[3] = e6;
        v.exp[4] = e7;
        return v;
    endfunction

    function automatic logic [30:0] outs();
        return {ifc.Gra, ifc.Grb, ifc.Grc, ifc.Rin, ifc.Rout, ifc.BAout,
                ifc.PCout, ifc.PCin, ifc.IncPC, ifc.IRin, ifc.MARin,
                ifc.MDRin, ifc.MDRout, ifc.MDRread, ifc.wren,
                ifc.Yin, ifc.Zlowin, ifc.Zhighin, ifc.ZLowout, ifc.ZHighout,
                ifc.HIout, ifc.LOout, ifc.Cout, ifc.InPortout, ifc.OPin,
                ifc.conffin, ifc.ALUselect, ifc.run};
    endfunction

    task automatic chk(input logic [30:0] exp, input string nm);
        logic [30:0] got;
        got = outs();
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", nm, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic fetch(input string nm);
        chk(F0, {nm, " T0"}); tick();
        chk(F1, {nm, " T1"}); tick();
        chk(F2, {nm, " T2"}); tick();
    endtask

    task automatic set_op(input logic [4:0] op);
        ifc.ir = {op, 27'h0ABCDEF};
    endtask

    vec_t tbl[22];

    initial begin
        tbl[0]  = mk(5'b00011, 0, 3, E_RRY, GRC|ROUT|ZLOWIN|alu(0)|RUN, E_WB, NONE, NONE);
        tbl[1]  = mk(5'b00100, 0, 3, E_RRY, GRC|ROUT|ZLOWIN|alu(1)|RUN, E_WB, NONE, NONE);
        tbl[2]  = mk(5'b00101, 0, 3, E_RRY, GRC|ROUT|ZLOWIN|alu(2)|RUN, E_WB, NONE, NONE);
        tbl[3]  = mk(5'b00110, 0, 3, E_RRY, GRC|ROUT|ZLOWIN|alu(3)|RUN, E_WB, NONE, NONE);
        tbl[4]  = mk(5'b01100, 0, 3, E_RRY, COUT|ZLOWIN|alu(0)|RUN, E_WB, NONE, NONE);
        tbl[5]  = mk(5'b01101, 0, 3, E_RRY, COUT|ZLOWIN|alu(2)|RUN, E_WB, NONE, NONE);
        tbl[6]  = mk(5'b01110, 0, 3, E_RRY, COUT|ZLOWIN|alu(3)|RUN, E_WB, NONE, NONE);
        tbl[7]  = mk(5'b00001, 0, 3, E_BAY, E_CZ, E_WB, NONE, NONE);
        tbl[8]  = mk(5'b00000, 0, 5, E_BAY, E_CZ, E_ZMAR, MDRREAD|MDRIN|RUN,
                     MDROUT|GRA|RIN|RUN);
        tbl[9]  = mk(5'b00010, 0, 5, E_BAY, E_CZ, E_ZMAR, GRA|ROUT|MDRIN|RUN,
                     WREN|RUN);
        tbl[10] = mk(5'b10011, 0, 4, GRA|ROUT|CONFFIN|RUN, PCOUT|YIN|RUN, E_CZ,
                     ZLOWOUT|RUN, NONE);
        tbl[11] = mk(5'b10011, 1, 4, GRA|ROUT|CONFFIN|RUN, PCOUT|YIN|RUN, E_CZ,
                     ZLOWOUT|PCIN|RUN, NONE);
        tbl[12] = mk(5'b10101, 0, 1, GRA|ROUT|PCIN|RUN, NONE, NONE, NONE, NONE);
        tbl[13] = mk(5'b10100, 0, 2, PCOUT|GRB|RIN|RUN, GRA|ROUT|PCIN|RUN,
                     NONE, NONE, NONE);
        tbl[14] = mk(5'b10110, 0, 1, INPORT|GRA|RIN|RUN, NONE, NONE, NONE, NONE);
        tbl[15] = mk(5'b10111, 0, 1, GRA|ROUT|OPIN|RUN, NONE, NONE, NONE, NONE);
        tbl[16] = mk(5'b11001, 0, 1, HIOUT|GRA|RIN|RUN, NONE, NONE, NONE, NONE);
        tbl[17] = mk(5'b11000, 0, 1, LOOUT|GRA|RIN|RUN, NONE, NONE, NONE, NONE);
        tbl[18] = mk(5'b11010, 0, 1, RUN, NONE, NONE, NONE, NONE);
        tbl[19] = mk(5'b11111, 0, 1, RUN, NONE, NONE, NONE, NONE);
        tbl[20] = mk(5'b00111, 0, 1, RUN, NONE, NONE, NONE, NONE);
        tbl[21] = mk(5'b10000, 1, 1, RUN, NONE, NONE, NONE, NONE);

        clr = 1'b1;
        ifc.con = 1'b0;
        ifc.mem_rdy = 1'b1;
        set_op(5'b00011);

        // two reset cycles, then release
        tick(); tick();
        chk(NONE, "reset RST");
        clr = 1'b0;
        tick();

        foreach (tbl[i]) begin
            set_op(tbl[i].op);
            ifc.con = tbl[i].con;
            fetch($sformatf("vec%0d", i));
            for (int k = 0; k < int'(tbl[i].n); k++) begin
                chk(tbl[i].exp[k], $sformatf("vec%0d T%0d", i, k + 3));
                tick();
            end
        end
        chk(F0, "table end T0");

        // T1 memory wait, mem_rdy ignored in T0
        set_op(5'b11010);
        ifc.mem_rdy = 1'b0;
        tick();
        chk(F1, "t1wait T1a"); tick();
        chk(F1, "t1wait T1b");
        ifc.mem_rdy = 1'b1;
        tick();
        chk(F2, "t1wait T2"); tick();
        chk(RUN, "t1wait T3"); tick();

        // ld with three wait cycles in T6
        set_op(5'b00000);
        fetch("ldw");
        chk(E_BAY, "ldw T3"); tick();
        chk(E_CZ, "ldw T4");
        ifc.mem_rdy = 1'b0;
        tick();
        chk(E_ZMAR, "ldw T5"); tick();
        for (int k = 0; k < 4; k++) begin
            chk(MDRREAD | MDRIN | RUN, $sformatf("ldw T6 hold%0d", k));
            if (k == 3) ifc.mem_rdy = 1'b1;
            tick();
        end
        chk(MDROUT | GRA | RIN | RUN, "ldw T7"); tick();
        chk(F0, "ldw back T0");

        // halt: parked until clr
        set_op(5'b11011);
        fetch("halt");
        chk(RUN, "halt T3"); tick();
        for (int k = 0; k < 10; k++) begin
            ifc.mem_rdy = k[0];
            chk(NONE, $sformatf("halt hold%0d", k));
            tick();
        end
        ifc.mem_rdy = 1'b1;
        clr = 1'b1;
        tick();
        chk(NONE, "halt clr RST");
        clr = 1'b0;
        tick();
        chk(F0, "halt release T0");

        // st: clr during T7 memory wait
        set_op(5'b00010);
        fetch("stclr");
        chk(E_BAY, "stclr T3"); tick();
        chk(E_CZ, "stclr T4"); tick();
        chk(E_ZMAR, "stclr T5"); tick();
        chk(GRA | ROUT | MDRIN | RUN, "stclr T6");
        ifc.mem_rdy = 1'b0;
        tick();
        chk(WREN | RUN, "stclr T7a"); tick();
        chk(WREN | RUN, "stclr T7b");
        clr = 1'b1;
        tick();
        chk(NONE, "stclr RST");
        clr = 1'b0;
        ifc.mem_rdy = 1'b1;
        tick();
        chk(F0, "stclr release T0");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
